// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : streams a length-prefixed byte image into instruction memory
//               and holds the core in reset until the image is complete.
// Optional    : IMEM_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error
);

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd6,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK  = 3'd5,
`endif
    S_ERR    = 3'd7
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [ADDR_WIDTH:0]   words_rem_q, words_rem_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [15:0]           len_full;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            sum_next;
  assign sum_next = sum_q + byte_in;
`endif

  assign len_full   = {byte_in, len_lo_q};
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    words_rem_d = words_rem_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    byte_ready  = 1'b0;
    imem_we     = 1'b0;
    cpu_rst     = 1'b1;
    done        = 1'b0;
    error       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        done    = (state_q == S_DONE);
        cpu_rst = (state_q != S_DONE);
        error   = (state_q == S_ERR);
        if (start) begin
          state_d = S_LEN_LO;
          addr_d  = '0;
          idx_d   = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
        end
      end

      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          len_lo_d = byte_in;
          state_d  = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (len_full == 16'd0) begin
            state_d = S_DONE;
          end else if ({16'd0, len_full} > CAPACITY) begin
            state_d = S_ERR;
          end else begin
            words_rem_d = (ADDR_WIDTH+1)'(len_full);
            state_d     = S_DATA;
          end
        end
      end

      S_DATA: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          case (idx_q)
            2'd0:    wdata_d[7:0]   = byte_in;
            2'd1:    wdata_d[15:8]  = byte_in;
            2'd2:    wdata_d[23:16] = byte_in;
            default: wdata_d[31:24] = byte_in;
          endcase
          idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_next;
`endif
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        imem_we     = 1'b1;
        addr_d      = addr_q + ADDR_WIDTH'(1);
        words_rem_d = words_rem_q - (ADDR_WIDTH+1)'(1);
        // idx has already wrapped to 0 after the fourth byte
        if (words_rem_q == (ADDR_WIDTH+1)'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          state_d = (sum_next == 8'h00) ? S_DONE : S_ERR;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_lo_q    <= 8'h00;
      words_rem_q <= '0;
      idx_q       <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      words_rem_q <= words_rem_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : randomized self-checking bench against an image-level model.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int AW  = 8;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          error;

  int checks = 0;
  int failures = 0;

  logic [31:0]      img[$];
  logic [AW+31:0]   exp_q[$];
  logic [AW+31:0]   obs_q[$];

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) obs_q.push_back({imem_addr, imem_wdata});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_writes();
    int n;
    check_eq("wr_count", 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq("wr_entry", 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  // Presents one byte after an idle gap and returns at the negedge after the transfer.
  task automatic send_byte(input logic [7:0] b, input int stall, input bit with_start);
    int guard;
    repeat (stall) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    start      = with_start;
    guard      = 0;
    while (!byte_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check_eq("ready_timeout", 64'(byte_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  // Words come from img, padded with random words; must start at a negedge.
  task automatic do_load(input logic [15:0] len, input int st_lo, input int st_hi,
                         input logic [7:0] ck_adj);
    logic [7:0]    sum;
    logic [7:0]    b;
    logic [31:0]   w;
    logic [AW-1:0] a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("lenlo_ready", 64'(byte_ready), 64'd1);
    check_eq("lenlo_cpu_rst", 64'(cpu_rst), 64'd1);
    check_eq("lenlo_done", 64'(done), 64'd0);
    check_eq("lenlo_error", 64'(error), 64'd0);
    send_byte(len[7:0], $urandom_range(st_lo, st_hi), 1'b0);
    send_byte(len[15:8], $urandom_range(st_lo, st_hi), 1'b0);
    if (len == 16'd0) begin
      check_eq("zero_done", 64'(done), 64'd1);
      check_eq("zero_cpu_rst", 64'(cpu_rst), 64'd0);
      check_eq("zero_ready", 64'(byte_ready), 64'd0);
    end else if (int'(len) > CAP) begin
      check_eq("big_error", 64'(error), 64'd1);
      check_eq("big_cpu_rst", 64'(cpu_rst), 64'd1);
      check_eq("big_done", 64'(done), 64'd0);
      check_eq("big_ready", 64'(byte_ready), 64'd0);
    end else begin
      sum = 8'h00;
      for (int i = 0; i < int'(len); i++) begin
        w = (i < img.size()) ? img[i] : $urandom;
        a = AW'(i);
        exp_q.push_back({a, w});
        for (int k = 0; k < 4; k++) begin
          b   = 8'((w >> (8 * k)) % 256);
          sum = sum + b;
          send_byte(b, $urandom_range(st_lo, st_hi), ($urandom_range(0, 7) == 0));
        end
        check_eq("we_latency", 64'(imem_we), 64'd1);
        check_eq("we_ready_low", 64'(byte_ready), 64'd0);
        check_eq("we_addr", 64'(imem_addr), 64'(a));
        check_eq("we_data", 64'(imem_wdata), 64'(w));
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      begin
        logic [7:0] ck;
        bit ok;
        ck = ck_adj - sum;
        ok = ((int'(sum) + int'(ck)) % 256) == 0;
        send_byte(ck, $urandom_range(st_lo, st_hi), 1'b0);
        check_eq("ck_done", 64'(done), 64'(ok));
        check_eq("ck_error", 64'(error), 64'(!ok));
        check_eq("ck_cpu_rst", 64'(cpu_rst), 64'(!ok));
      end
`else
      @(negedge clk);
      check_eq("end_done", 64'(done), 64'd1);
      check_eq("end_cpu_rst", 64'(cpu_rst), 64'd0);
      check_eq("end_ck_adj_unused", 64'(ck_adj & 8'h00), 64'd0);
`endif
    end
    compare_writes();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'(byte_ready), 64'd0);
    check_eq("rst_we", 64'(imem_we), 64'd0);
    check_eq("rst_addr", 64'(imem_addr), 64'd0);
    check_eq("rst_wdata", 64'(imem_wdata), 64'd0);
    check_eq("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_error", 64'(error), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_hold", 64'(cpu_rst), 64'd1);

    // Two-instruction image
    img = '{32'h00100513, 32'h00200593};
    do_load(16'd2, 0, 0, 8'h00);

    // Empty image, then oversize length, then recovery from ERR
    do_load(16'd0, 0, 0, 8'h00);
    do_load(16'd257, 0, 0, 8'h00);

    // Stalls of three idle cycles between every byte
    img = '{32'hDEADBEEF};
    do_load(16'd1, 3, 3, 8'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
    img = '{32'h04030201};
    do_load(16'd1, 0, 1, 8'h00);
    do_load(16'd1, 0, 1, 8'h01);
`endif

    // Reset in DATA after two bytes drops the partial word
    img.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h13, 0, 1'b0);
    send_byte(8'h05, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
    check_eq("midrst_ready", 64'(byte_ready), 64'd0);
    check_eq("midrst_addr", 64'(imem_addr), 64'd0);
    check_eq("midrst_wdata", 64'(imem_wdata), 64'd0);
    repeat (2) @(negedge clk);
    compare_writes();
    img = '{32'h00100513, 32'h00200593};
    do_load(16'd2, 0, 1, 8'h00);

    // Full-capacity image leaves the address wrapped to zero
    img.delete();
    do_load(16'(CAP), 0, 0, 8'h00);
    check_eq("wrap_addr", 64'(imem_addr), 64'd0);

    // Randomized mix of loads
    for (int t = 0; t < 25; t++) begin
      int kind;
      logic [15:0] len;
      logic [7:0] adj;
      kind = $urandom_range(0, 9);
      if (kind == 0)      len = 16'd0;
      else if (kind == 1) len = 16'($urandom_range(CAP + 1, 65535));
      else                len = 16'($urandom_range(1, 6));
      adj = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      do_load(len, 0, 2, adj);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. The single-cycle core fetches from this memory; this block fills it.
- Receives a byte stream, for example from a UART receiver, with a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them to consecutive word addresses from 0.
- Holds the core in reset until a complete image has loaded.

Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse that begins a load; ignored in LEN_LO, LEN_HI, DATA, WRITE and CHECK
- byte_in  input  8  stream byte
- byte_valid  input  1  byte_in is valid this cycle
- byte_ready  output  1  loader accepts byte_in this cycle; a transfer occurs when valid and ready are both high
- imem_we  output  1  instruction memory write strobe, one cycle per word
- imem_addr  output  ADDR_WIDTH  word address for the write
- imem_wdata  output  32  instruction word to write
- cpu_rst  output  1  reset to the core; high except in DONE
- done  output  1  image loaded; high in DONE
- error  output  1  load aborted; high in ERR

Behaviour:
- Reset values:
  - byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_rst=1, done=0, error=0, state=IDLE.
  - Internal word count, byte index and checksum all cleared.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERR.
- IDLE:
  - byte_ready=0.
  - start -> LEN_LO. Clear imem_addr, byte index and checksum.
- LEN_LO:
  - byte_ready=1.
  - On transfer, latch len[7:0] -> LEN_HI.
- LEN_HI:
  - byte_ready=1.
  - On transfer, latch len[15:8].
  - Same cycle: len==0 -> DONE; len>2^ADDR_WIDTH -> ERR; otherwise -> DATA.
- DATA:
  - byte_ready=1.
  - On transfer, write the byte into imem_wdata lane [8*idx+7:8*idx] and increment idx (0..3). Byte 0 is the LSB.
  - The transfer with idx==3 -> WRITE.
- WRITE (exactly one cycle):
  - byte_ready=0, imem_we=1, imem_addr and imem_wdata stable.
  - Next cycle: imem_addr increments and words_remaining decrements.
  - words_remaining reaches 0 -> CHECK if enabled, else DONE. Otherwise -> DATA with idx=0.
- Throughput: at most 4 data bytes per 5 cycles. Latency from the 4th byte's transfer to imem_we is 1 cycle.
- Address wrap:
  - imem_addr never wraps inside a load; the length check guarantees this.
  - A full load of 2^ADDR_WIDTH words leaves imem_addr at 0 after the final increment. This is permitted.
- DONE:
  - cpu_rst=0, done=1, byte_ready=0.
  - start -> reload: to LEN_LO, cpu_rst=1 on the next cycle, done=0.
- ERR:
  - error=1, cpu_rst=1, byte_ready=0.
  - Only start or rst leaves ERR; start -> LEN_LO and clears error.
- Stalls: byte_valid low inside any receiving state holds all state; there is no timeout.
- rst mid-load:
  - Immediately on the next edge, return to IDLE with reset values.
  - A pending WRITE is dropped; no imem_we is issued.
- imem_we is never high outside WRITE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) accumulates every data byte; length bytes are excluded.
  - After the last WRITE, go to CHECK with byte_ready=1 and accept one checksum byte.
  - sum+byte==8'h00 -> DONE; else -> ERR.
  - Words already written are not erased on ERR.
- Undefined:
  - CHECK state and the sum register are absent.
  - After the last WRITE, go directly to DONE.

Test Plan:
- Load 2 words: start, bytes 02 00 | 13 05 10 00 | 93 05 20 00 -> two imem_we pulses: addr0=0x00100513, addr1=0x00200593. done=1 and cpu_rst=0 one cycle after the second WRITE, or after CHECK when enabled.
- Zero length: start, bytes 00 00 -> no imem_we; DONE on the cycle after the LEN_HI transfer.
- Oversize, ADDR_WIDTH=8: length bytes 01 01 (257) -> ERR, error=1, cpu_rst=1, no writes. A following start -> LEN_LO, error=0.
- Backpressure/stall: drop byte_valid for 3 cycles between each byte of a 1-word load 0xDEADBEEF (EF BE AD DE) -> single write of 0xDEADBEEF to addr 0. byte_ready is low during WRITE.
- rst asserted in DATA after 2 bytes -> next cycle IDLE, cpu_rst=1, no imem_we ever. A new start with a full image loads correctly from addr 0.
- With IMEM_LOADER_CHECKSUM_EN, image 01 00 | 01 02 03 04:
  - checksum F6 -> DONE.
  - checksum F7 -> ERR, with one write of 0x04030201 already issued.
